// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: parity modes, FSM
// state encoding, FIFO entry flag layout and small bit-level helpers.
package uart_pkg;

    localparam logic [1:0] PARITY_NONE = 2'd0;
    localparam logic [1:0] PARITY_EVEN = 2'd1;
    localparam logic [1:0] PARITY_ODD  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } rxState_t;

    // FIFO entry is {flags, data}; flags sit above the payload bits.
    typedef struct packed {
        logic brk;
        logic frameErr;
        logic parityErr;
    } rxFlags_t;

    localparam int FLAG_BITS = 3;

    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

    // Zero-extended payloads do not change the XOR, so 9 bits covers 5..9.
    function automatic logic parityBit(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock pointer FIFO; the extra pointer MSB distinguishes full from empty.
module sync_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     nrst_i,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wrData,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : gDepthChk
        $error("sync_fifo DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wrPtr_r;
    logic [AW:0]      rdPtr_r;
    logic             doPush_s;
    logic             doPop_s;

    assign empty    = (wrPtr_r == rdPtr_r);
    assign full     = (wrPtr_r[AW] != rdPtr_r[AW]) && (wrPtr_r[AW-1:0] == rdPtr_r[AW-1:0]);
    assign count    = wrPtr_r - rdPtr_r;
    assign doPop_s  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign doPush_s = push && (!full || doPop_s);
    assign rdData   = mem_r[rdPtr_r[AW-1:0]];

    // Read/write pointer update.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            wrPtr_r <= {(AW + 1){1'b0}};
            rdPtr_r <= {(AW + 1){1'b0}};
        end else begin
            if (doPush_s) begin
                wrPtr_r <= wrPtr_r + PTR_ONE;
            end
            if (doPop_s) begin
                rdPtr_r <= rdPtr_r + PTR_ONE;
            end
        end
    end

    // Storage write; cleared on reset so the head reads zero.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (doPush_s) begin
                mem_r[wrPtr_r[AW-1:0]] <= wrData;
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver with majority-vote sampling, start-glitch
// rejection and a flagged word FIFO behind a valid/ready handshake.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 50_000_000,
    parameter int BIT_RATE_HZ  = 31250,
    parameter int PAYLOAD_BITS = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clk_i,
    input  logic                    nrst_i,
    input  logic                    rxData_i,
    input  logic                    clrErr_i,
    output logic [PAYLOAD_BITS-1:0] data_o,
    output logic                    parityErr_o,
    output logic                    frameErr_o,
    output logic                    break_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    overrun_o,
    output logic                    busy_o
);

    localparam int CYCLES_PER_BIT = CLK_FREQ_HZ / BIT_RATE_HZ;
    localparam int CNT_W          = $clog2(CYCLES_PER_BIT) + 1;
    localparam int CENTRE         = CYCLES_PER_BIT / 2;
    localparam int ENTRY_W        = PAYLOAD_BITS + FLAG_BITS;
    localparam int CNT_AW         = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] CNT_S0  = CNT_W'(CENTRE - 1);
    localparam logic [CNT_W-1:0] CNT_S1  = CNT_W'(CENTRE);
    localparam logic [CNT_W-1:0] CNT_S2  = CNT_W'(CENTRE + 1);
    localparam logic [CNT_W-1:0] CNT_MAJ = CNT_W'(CENTRE + 2);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [3:0]       LAST_DATA = 4'(PAYLOAD_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic             ODD_MODE  = (PARITY_MODE == int'(PARITY_ODD));
    localparam logic             HAS_PARITY = (PARITY_MODE != int'(PARITY_NONE));

    if (CYCLES_PER_BIT < 8) begin : gRateChk
        $error("uart_rx_fifo needs at least 8 clock cycles per bit");
    end
    if ((PAYLOAD_BITS < 5) || (PAYLOAD_BITS > 9)) begin : gPayloadChk
        $error("uart_rx_fifo PAYLOAD_BITS must be 5..9");
    end
    if ((PARITY_MODE != int'(PARITY_NONE)) && (PARITY_MODE != int'(PARITY_EVEN)) &&
        (PARITY_MODE != int'(PARITY_ODD))) begin : gParityChk
        $error("uart_rx_fifo PARITY_MODE must be 0, 1 or 2");
    end
    if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : gStopChk
        $error("uart_rx_fifo STOP_BITS must be 1 or 2");
    end

    rxState_t                state_r;
    rxState_t                stateNext_s;
    logic                    rxMeta_r;
    logic                    rxSync_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [3:0]              bitCnt_r;
    logic                    stopCnt_r;
    logic [2:0]              samples_r;
    logic [PAYLOAD_BITS-1:0] shift_r;
    logic                    parityErr_r;
    logic                    frameErr_r;
    logic                    overrun_r;
    logic                    cntClr_s;
    logic                    push_s;
    logic                    bitEnd_s;
    logic                    majTime_s;
    logic                    majBit_s;
    logic                    frameFlag_s;
    rxFlags_t                pushFlags_s;
    rxFlags_t                headFlags_s;
    logic [ENTRY_W-1:0]      headEntry_s;
    logic                    fifoFull_s;
    logic                    fifoEmpty_s;
    logic [CNT_AW:0]         fifoCount_s;
    logic                    popReq_s;
    logic                    overrunSet_s;

    assign bitEnd_s  = (cnt_r == CNT_END);
    assign majTime_s = (cnt_r == CNT_MAJ);
    assign majBit_s  = majority3(samples_r);

    // Input synchroniser and FSM state register.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            rxMeta_r <= 1'b1;
            rxSync_r <= 1'b1;
            state_r  <= ST_IDLE;
        end else begin
            rxMeta_r <= rxData_i;
            rxSync_r <= rxMeta_r;
            state_r  <= stateNext_s;
        end
    end

    // Next-state, counter clear and push decode.
    always_comb begin
        stateNext_s = state_r;
        cntClr_s    = 1'b0;
        push_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cntClr_s = 1'b1;
                if (!rxSync_r) begin
                    stateNext_s = ST_START;
                end else begin
                    stateNext_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (majTime_s && majBit_s) begin
                    stateNext_s = ST_IDLE;
                    cntClr_s    = 1'b1;
                end else if (bitEnd_s) begin
                    stateNext_s = ST_DATA;
                    cntClr_s    = 1'b1;
                end else begin
                    stateNext_s = ST_START;
                end
            end
            ST_DATA: begin
                if (bitEnd_s) begin
                    cntClr_s = 1'b1;
                    if (bitCnt_r == LAST_DATA) begin
                        stateNext_s = HAS_PARITY ? ST_PARITY : ST_STOP;
                    end else begin
                        stateNext_s = ST_DATA;
                    end
                end else begin
                    stateNext_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bitEnd_s) begin
                    stateNext_s = ST_STOP;
                    cntClr_s    = 1'b1;
                end else begin
                    stateNext_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                // Pushing at the last stop centre leaves half a bit to resync.
                if (majTime_s && (stopCnt_r == STOP_LAST)) begin
                    push_s      = 1'b1;
                    cntClr_s    = 1'b1;
                    stateNext_s = rxSync_r ? ST_IDLE : ST_WAIT_IDLE;
                end else if (bitEnd_s) begin
                    cntClr_s    = 1'b1;
                    stateNext_s = ST_STOP;
                end else begin
                    stateNext_s = ST_STOP;
                end
            end
            ST_WAIT_IDLE: begin
                cntClr_s = 1'b1;
                if (rxSync_r) begin
                    stateNext_s = ST_IDLE;
                end else begin
                    stateNext_s = ST_WAIT_IDLE;
                end
            end
            default: begin
                cntClr_s    = 1'b1;
                stateNext_s = ST_IDLE;
            end
        endcase
    end

    // Bit timing, majority samples, payload shift and per-frame error flags.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            cnt_r       <= {CNT_W{1'b0}};
            bitCnt_r    <= 4'd0;
            stopCnt_r   <= 1'b0;
            samples_r   <= 3'b111;
            shift_r     <= {PAYLOAD_BITS{1'b0}};
            parityErr_r <= 1'b0;
            frameErr_r  <= 1'b0;
        end else begin
            if (cntClr_s) begin
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
            if (cnt_r == CNT_S0) begin
                samples_r[0] <= rxSync_r;
            end
            if (cnt_r == CNT_S1) begin
                samples_r[1] <= rxSync_r;
            end
            if (cnt_r == CNT_S2) begin
                samples_r[2] <= rxSync_r;
            end
            case (state_r)
                ST_IDLE: begin
                    bitCnt_r    <= 4'd0;
                    stopCnt_r   <= 1'b0;
                    parityErr_r <= 1'b0;
                    frameErr_r  <= 1'b0;
                end
                ST_DATA: begin
                    if (majTime_s) begin
                        shift_r <= {majBit_s, shift_r[PAYLOAD_BITS-1:1]};
                    end
                    if (bitEnd_s) begin
                        if (bitCnt_r == LAST_DATA) begin
                            bitCnt_r <= 4'd0;
                        end else begin
                            bitCnt_r <= bitCnt_r + 4'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (majTime_s && (majBit_s != parityBit(9'(shift_r), ODD_MODE))) begin
                        parityErr_r <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (majTime_s && !majBit_s) begin
                        frameErr_r <= 1'b1;
                    end
                    if (bitEnd_s) begin
                        stopCnt_r <= stopCnt_r + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Flags for the word being pushed include the current stop sample.
    always_comb begin
        frameFlag_s           = frameErr_r | ~majBit_s;
        pushFlags_s.parityErr = parityErr_r;
        pushFlags_s.frameErr  = frameFlag_s;
        pushFlags_s.brk       = (shift_r == {PAYLOAD_BITS{1'b0}}) && frameFlag_s;
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) uFifo (
        .clk_i  (clk_i),
        .nrst_i (nrst_i),
        .push   (push_s),
        .wrData ({pushFlags_s, shift_r}),
        .pop    (popReq_s),
        .rdData (headEntry_s),
        .full   (fifoFull_s),
        .empty  (fifoEmpty_s),
        .count  (fifoCount_s)
    );

    assign popReq_s     = ready_i && (fifoCount_s != {(CNT_AW + 1){1'b0}});
    assign overrunSet_s = push_s && fifoFull_s && !popReq_s;

    // Sticky overrun; a new drop wins over a simultaneous clear.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            overrun_r <= 1'b0;
        end else if (overrunSet_s) begin
            overrun_r <= 1'b1;
        end else if (clrErr_i) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign headFlags_s = rxFlags_t'(headEntry_s[ENTRY_W-1 -: FLAG_BITS]);
    assign data_o      = headEntry_s[PAYLOAD_BITS-1:0];
    assign parityErr_o = headFlags_s.parityErr;
    assign frameErr_o  = headFlags_s.frameErr;
    assign break_o     = headFlags_s.brk;
    assign valid_o     = !fifoEmpty_s;
    assign overrun_o   = overrun_r;
    assign busy_o      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench: one DUT at the default 31250 baud, two fast-rate DUTs
// (8N1 and 7E1, 16 clocks per bit) for the remaining scenarios.
module tb_uart_rx_fifo;

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } expWord_t;

    localparam int FAST_CPB = 16;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic lineA = 1'b1, lineB = 1'b1, lineP = 1'b1;
    logic clrA = 1'b0, clrB = 1'b0, clrP = 1'b0;
    logic readyA = 1'b1, readyB = 1'b1, readyP = 1'b1;
    logic [7:0] dataA, dataB;
    logic [6:0] dataP;
    logic perrA, ferrA, brkA, validA, ovrA, busyA;
    logic perrB, ferrB, brkB, validB, ovrB, busyB;
    logic perrP, ferrP, brkP, validP, ovrP, busyP;

    expWord_t expA[$], expB[$], expP[$];
    int nChecks = 0;
    int nPass = 0;

    always #5 clk = ~clk;

    uart_rx_fifo uDutA (
        .clk_i(clk), .nrst_i(nrst), .rxData_i(lineA), .clrErr_i(clrA),
        .data_o(dataA), .parityErr_o(perrA), .frameErr_o(ferrA), .break_o(brkA),
        .valid_o(validA), .ready_i(readyA), .overrun_o(ovrA), .busy_o(busyA)
    );

    uart_rx_fifo #(.BIT_RATE_HZ(3_125_000)) uDutB (
        .clk_i(clk), .nrst_i(nrst), .rxData_i(lineB), .clrErr_i(clrB),
        .data_o(dataB), .parityErr_o(perrB), .frameErr_o(ferrB), .break_o(brkB),
        .valid_o(validB), .ready_i(readyB), .overrun_o(ovrB), .busy_o(busyB)
    );

    uart_rx_fifo #(.BIT_RATE_HZ(3_125_000), .PAYLOAD_BITS(7), .PARITY_MODE(1)) uDutP (
        .clk_i(clk), .nrst_i(nrst), .rxData_i(lineP), .clrErr_i(clrP),
        .data_o(dataP), .parityErr_o(perrP), .frameErr_o(ferrP), .break_o(brkP),
        .valid_o(validP), .ready_i(readyP), .overrun_o(ovrP), .busy_o(busyP)
    );

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) begin
            nPass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic expWord_t mkExp(input logic [8:0] d, input logic p, input logic f, input logic b);
        expWord_t e;
        e.data = d;
        e.perr = p;
        e.ferr = f;
        e.brk  = b;
        return e;
    endfunction

    task automatic checkWord(input string who, input expWord_t e, input logic [8:0] d,
                             input logic p, input logic f, input logic b);
        checkEq({who, "_data"}, 32'(d), 32'(e.data));
        checkEq({who, "_parityErr"}, 32'(p), 32'(e.perr));
        checkEq({who, "_frameErr"}, 32'(f), 32'(e.ferr));
        checkEq({who, "_break"}, 32'(b), 32'(e.brk));
    endtask

    // Pop-side monitors: every accepted head word is matched against the queue.
    always @(negedge clk) begin
        if (nrst && validA && readyA) begin
            if (expA.size() == 0) checkEq("A_unexpected_word", 32'(validA), 32'd0);
            else checkWord("A", expA.pop_front(), 9'(dataA), perrA, ferrA, brkA);
        end
    end

    always @(negedge clk) begin
        if (nrst && validB && readyB) begin
            if (expB.size() == 0) checkEq("B_unexpected_word", 32'(validB), 32'd0);
            else checkWord("B", expB.pop_front(), 9'(dataB), perrB, ferrB, brkB);
        end
    end

    always @(negedge clk) begin
        if (nrst && validP && readyP) begin
            if (expP.size() == 0) checkEq("P_unexpected_word", 32'(validP), 32'd0);
            else checkWord("P", expP.pop_front(), 9'(dataP), perrP, ferrP, brkP);
        end
    end

    task automatic setLine(input int which, input logic v);
        case (which)
            0: lineA = v;
            1: lineB = v;
            default: lineP = v;
        endcase
    endtask

    // parBit < 0 sends no parity bit; spikeBit >= 0 inverts that data bit for one cycle at its centre.
    task automatic sendFrame(input int which, input int cpb, input logic [8:0] data, input int nbits,
                             input int parBit, input logic stopV, input int spikeBit);
        logic b;
        @(posedge clk);
        #1 setLine(which, 1'b0);
        repeat (cpb) @(posedge clk);
        #1;
        for (int i = 0; i < nbits; i++) begin
            b = data[i];
            setLine(which, b);
            if (i == spikeBit) begin
                repeat (cpb / 2) @(posedge clk);
                #1 setLine(which, ~b);
                @(posedge clk);
                #1 setLine(which, b);
                repeat (cpb / 2 - 1) @(posedge clk);
            end else begin
                repeat (cpb) @(posedge clk);
            end
            #1;
        end
        if (parBit >= 0) begin
            setLine(which, parBit[0]);
            repeat (cpb) @(posedge clk);
            #1;
        end
        setLine(which, stopV);
        repeat (cpb) @(posedge clk);
        #1 setLine(which, 1'b1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkEq("reset_B_flags", {26'd0, validB, perrB, ferrB, brkB, ovrB, busyB}, 32'd0);
        checkEq("reset_B_data", 32'(dataB), 32'd0);
        @(posedge clk);
        #1 nrst = 1'b1;
        repeat (5) @(posedge clk);

        // Default rate: 0x90, valid exactly one cycle after the last stop majority point.
        expA.push_back(mkExp(9'h090, 1'b0, 1'b0, 1'b0));
        fork
            sendFrame(0, 1600, 9'h090, 8, -1, 1'b1, -1);
            begin
                @(posedge clk);
                repeat (3 + 9 * 1600 + 800 + 2) @(posedge clk);
                @(negedge clk);
                checkEq("A_valid_before_push", 32'(validA), 32'd0);
                @(posedge clk);
                @(negedge clk);
                checkEq("A_valid_after_push", 32'(validA), 32'd1);
            end
        join
        repeat (20) @(posedge clk);

        // 7E1: 0x41 has even weight, so parity 0 is clean and parity 1 is an error.
        expP.push_back(mkExp(9'h041, 1'b0, 1'b0, 1'b0));
        sendFrame(2, FAST_CPB, 9'h041, 7, 0, 1'b1, -1);
        expP.push_back(mkExp(9'h041, 1'b1, 1'b0, 1'b0));
        sendFrame(2, FAST_CPB, 9'h041, 7, 1, 1'b1, -1);
        repeat (20) @(posedge clk);

        // Start glitch of a quarter bit: no word, FSM back to idle.
        @(posedge clk);
        #1 lineB = 1'b0;
        repeat (FAST_CPB / 4) @(posedge clk);
        #1 lineB = 1'b1;
        @(negedge clk);
        checkEq("B_busy_in_glitch", 32'(busyB), 32'd1);
        repeat (3 * FAST_CPB) @(posedge clk);
        @(negedge clk);
        checkEq("B_busy_after_glitch", 32'(busyB), 32'd0);
        checkEq("B_valid_after_glitch", 32'(validB), 32'd0);

        // One-cycle spike at the centre of data bit 0 is outvoted.
        expB.push_back(mkExp(9'h090, 1'b0, 1'b0, 1'b0));
        sendFrame(1, FAST_CPB, 9'h090, 8, -1, 1'b1, 0);
        repeat (20) @(posedge clk);

        // Overrun: five frames into a depth-4 FIFO with the consumer stalled.
        readyB = 1'b0;
        for (int v = 1; v <= 5; v++) begin
            if (v <= 4) expB.push_back(mkExp(9'(v), 1'b0, 1'b0, 1'b0));
            sendFrame(1, FAST_CPB, 9'(v), 8, -1, 1'b1, -1);
        end
        @(negedge clk);
        checkEq("B_overrun_set", 32'(ovrB), 32'd1);
        checkEq("B_valid_full", 32'(validB), 32'd1);
        @(posedge clk);
        #1 readyB = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        checkEq("B_drained", 32'(validB), 32'd0);
        checkEq("B_overrun_sticky", 32'(ovrB), 32'd1);
        @(posedge clk);
        #1 clrB = 1'b1;
        @(posedge clk);
        #1 clrB = 1'b0;
        @(negedge clk);
        checkEq("B_overrun_cleared", 32'(ovrB), 32'd0);

        // Full FIFO with push and pop in the same cycle: no drop, no overrun.
        readyB = 1'b0;
        for (int v = 1; v <= 4; v++) begin
            expB.push_back(mkExp(9'(v * 17), 1'b0, 1'b0, 1'b0));
            sendFrame(1, FAST_CPB, 9'(v * 17), 8, -1, 1'b1, -1);
        end
        expB.push_back(mkExp(9'h055, 1'b0, 1'b0, 1'b0));
        fork
            sendFrame(1, FAST_CPB, 9'h055, 8, -1, 1'b1, -1);
            begin
                @(posedge clk);
                repeat (3 + 9 * FAST_CPB + FAST_CPB / 2 + 2) @(posedge clk);
                #1 readyB = 1'b1;
                @(posedge clk);
                #1 readyB = 1'b0;
            end
        join
        @(negedge clk);
        checkEq("B_no_overrun_push_pop", 32'(ovrB), 32'd0);
        checkEq("B_valid_still_full", 32'(validB), 32'd1);
        @(posedge clk);
        #1 readyB = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        checkEq("B_drained_2", 32'(validB), 32'd0);

        // Break: line low for three frame times yields a single flagged 0x00.
        expB.push_back(mkExp(9'h000, 1'b0, 1'b1, 1'b1));
        @(posedge clk);
        #1 lineB = 1'b0;
        repeat (30 * FAST_CPB) @(posedge clk);
        @(negedge clk);
        checkEq("B_busy_in_break", 32'(busyB), 32'd1);
        checkEq("B_no_word_in_break", 32'(validB), 32'd0);
        @(posedge clk);
        #1 lineB = 1'b1;
        repeat (3 * FAST_CPB) @(posedge clk);
        @(negedge clk);
        checkEq("B_idle_after_break", 32'(busyB), 32'd0);
        expB.push_back(mkExp(9'h055, 1'b0, 1'b0, 1'b0));
        sendFrame(1, FAST_CPB, 9'h055, 8, -1, 1'b1, -1);
        repeat (20) @(posedge clk);

        // Reset after the 4th data bit of 0xAA discards the partial word.
        @(posedge clk);
        #1 lineB = 1'b0;
        repeat (FAST_CPB) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            #1 lineB = i[0];
            repeat (FAST_CPB) @(posedge clk);
        end
        @(negedge clk);
        checkEq("B_busy_midframe", 32'(busyB), 32'd1);
        @(posedge clk);
        #1 nrst = 1'b0;
        @(negedge clk);
        checkEq("B_reset_flags", {26'd0, validB, perrB, ferrB, brkB, ovrB, busyB}, 32'd0);
        checkEq("B_reset_data", 32'(dataB), 32'd0);
        @(posedge clk);
        #1 lineB = 1'b1;
        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;
        repeat (3 * FAST_CPB) @(posedge clk);
        expB.push_back(mkExp(9'h03C, 1'b0, 1'b0, 1'b0));
        sendFrame(1, FAST_CPB, 9'h03C, 8, -1, 1'b1, -1);
        repeat (20) @(posedge clk);

        checkEq("A_words_missing", 32'(expA.size()), 32'd0);
        checkEq("B_words_missing", 32'(expB.size()), 32'd0);
        checkEq("P_words_missing", 32'(expP.size()), 32'd0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised serial receiver. It is the successor of the fixed 8N1 MIDI front end and supports configurable word length, parity, stop bits and baud rate. Each bit is sampled with a 3-sample majority vote, and start-bit glitches are rejected. Received words go into an on-chip FIFO with per-word error flags, and a valid/ready handshake feeds the MIDI parser or any other byte consumer.

Parameters:
- CLK_FREQ_HZ, 50_000_000: system clock frequency.
- BIT_RATE_HZ, 31250: line baud rate. CYCLES_PER_BIT = CLK_FREQ_HZ/BIT_RATE_HZ; elaboration fails if it is below 8.
- PAYLOAD_BITS, 8: data bits per frame, legal range 5..9.
- PARITY_MODE, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: stop bits checked, 1 or 2.
- FIFO_DEPTH, 4: FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk_i  in  1  system clock
- nrst_i  in  1  asynchronous active-low reset
- rxData_i  in  1  asynchronous serial line, idle high
- clrErr_i  in  1  one-cycle pulse; clears overrun_o
- data_o  out  PAYLOAD_BITS  word at FIFO head
- parityErr_o  out  1  head word failed parity (0 when PARITY_MODE = 0)
- frameErr_o  out  1  head word had a low stop bit
- break_o  out  1  head word is a break (all-zero data plus frame error)
- valid_o  out  1  FIFO not empty
- ready_i  in  1  consumer accepts head; pop occurs when valid_o && ready_i
- overrun_o  out  1  sticky: a word was dropped because the FIFO was full
- busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset is asynchronous, active-low, on clk_i.
  - Reset values: all outputs 0 except data_o = 0; FIFO empty.
  - Both synchroniser flops reset to 1; FSM to IDLE; counters to 0.
- Input path: 2-flop synchroniser, then the sampler. Only the synchronised line drives the logic.
- Cycle counter: width $clog2(CYCLES_PER_BIT)+1, cleared on every bit boundary. Centre C = CYCLES_PER_BIT/2.
- Majority sample: the line is captured at counts C-1, C and C+1. The bit value is the 2-of-3 majority, valid at count C+2.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - IDLE: synchronised line low moves to START with the counter cleared.
  - START: at majority time, a result of 1 is a glitch and returns to IDLE with no push. A result of 0 stays until the bit end, then goes to DATA.
  - DATA: LSB first. The majority bit is shifted into bit PAYLOAD_BITS-1 and the register shifts right. The bit counter increments at each bit end. After PAYLOAD_BITS bits, go to PARITY if PARITY_MODE != 0, else to STOP.
  - PARITY: the sampled bit is compared to the XOR of the data (even mode) or its inverse (odd mode); a mismatch sets the parity error.
  - STOP: each stop bit is checked at majority time; any 0 sets the frame error. At majority time of the last stop bit the word and flags are pushed. Next state is IDLE if the line is high, else WAIT_IDLE. The push does not wait for the bit end, so there is half-bit resync margin.
  - WAIT_IDLE: stay until the line is high; this blocks false start detection during a break.
- Push/pop latency: a pushed word appears on data_o and valid_o on the cycle after the push. Outputs come straight from FIFO storage, not through an extra register.
- FIFO full + push without pop: the word is dropped and overrun_o is set the next cycle. Stored contents are unchanged.
- FIFO full + push + pop in the same cycle: both take effect; the count is unchanged and there is no overrun.
- FIFO empty: valid_o = 0, and ready_i is ignored.
- Overrun precedence: clrErr_i in the same cycle as a new overrun leaves overrun_o = 1.
- Reset mid-frame: FSM, counters and FIFO all return to reset values immediately, and the partial word is discarded.
- Parameter changes require re-elaboration; there is no runtime mode switching.

Decomposition:
- Shared package uart_pkg holds:
  - PARITY_NONE/EVEN/ODD constants;
  - FSM state encoding (3-bit);
  - the FIFO entry layout {break, frameErr, parityErr, data}.
- Sub-module sync_fifo (parameters WIDTH, DEPTH):
  - pointer-based, with an extra pointer bit for full/empty;
  - push/pop/full/empty/count ports;
  - instantiated with WIDTH = PAYLOAD_BITS+3.

Test Plan:
- Default parameters, frame 0x90 8N1 at 31250 baud, ready_i = 1 → one pop with data_o = 0x90 and all error flags 0. valid_o asserts 1 cycle after the last stop-bit majority point.
- PAYLOAD_BITS = 7, PARITY_MODE = 1, data 0x41 sent once with parity 0 and once with parity 1 → first word parityErr_o = 0, second word parityErr_o = 1, both data 0x41.
- Low pulse of CYCLES_PER_BIT/4 cycles, and separately a single-cycle high spike at a data-bit centre → no word pushed for the pulse; the spiked frame decodes correctly through the majority vote.
- ready_i = 0, FIFO_DEPTH+1 frames 0x01..0x05 with depth 4 → overrun_o = 1 and pops return 0x01..0x04. Then clrErr_i clears overrun_o; a full+push+pop cycle causes no overrun.
- Line held low for 3 frame times → one word 0x00 with frameErr_o = 1 and break_o = 1. No further words until the line goes high; a following 0x55 frame decodes cleanly.
- nrst_i asserted after the 4th data bit of 0xAA, released, then 0x3C sent → only 0x3C appears, and all outputs read reset values during reset.
